edge_stream_pipe: RTL and testbench

Parametrised streaming edge-detection engine: one frame of 24-bit RGB pixels in raster order in, one 8-bit result per pixel out, each tagged with its frame address offset. It replaces the fixed 12-count concat/sobel flow with real line buffers, a valid/ready handshake on both sides, configurable frame size and selectable output mode. It sits between the FPGA pixel-fetch logic and the result write-back logic.

---
 rtl/edge_stream_pipe.sv | 213 +++++++++++++++++++++
 tb/tb_edge_stream_pipe.sv | 261 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/edge_stream_pipe.sv
// rtl/edge_stream_pipe.sv - streaming 3x3 Sobel / threshold / gray edge engine with line buffers
//
// Accepts one frame of IMG_W x IMG_H RGB pixels in raster order and emits one
// 8-bit result per pixel tagged with its raster address.
// Ports:
//   clk, n_rst            clock, synchronous active-low reset
//   start, mode, threshold frame start (IDLE only) and per-frame configuration
//   in_valid/in_ready/rgb  input pixel stream
//   out_valid/out_ready    output stream handshake, out_pix/out_addr payload
//   busy, done, frame_err  status: frame active, end-of-frame pulse, sticky start-while-busy
module edge_stream_pipe #(
    parameter int IMG_W  = 640,
    parameter int IMG_H  = 480,
    parameter int ADDR_W = 19
) (
    input  logic              clk,
    input  logic              n_rst,
    input  logic              start,
    input  logic [1:0]        mode,
    input  logic [7:0]        threshold,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [23:0]       rgb,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [7:0]        out_pix,
    output logic [ADDR_W-1:0] out_addr,
    output logic              busy,
    output logic              done,
    output logic              frame_err
);
    localparam int NPIX = IMG_W * IMG_H;
    localparam int CW   = $clog2(NPIX + IMG_W + 2);
    localparam int XW   = $clog2(IMG_W);
    localparam int YW   = $clog2(IMG_H);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FLUSH, S_DONE} state_t;

    state_t            state_q;
    logic [CW-1:0]     cnt_q;          // steps taken this frame (raster index of newest pixel)
    logic [XW-1:0]     col_q;          // column of the newest pixel
    logic [XW-1:0]     ccol_q;         // column of the next centre pixel to be output
    logic [YW-1:0]     crow_q;         // row of the next centre pixel to be output
    logic [1:0]        mode_q;
    logic [7:0]        thr_q;
    logic              out_valid_q;
    logic [7:0]        out_pix_q;
    logic [ADDR_W-1:0] out_addr_q;
    logic              busy_q;
    logic              done_q;
    logic              ferr_q;
    logic [7:0]        lb0_q [IMG_W];  // line n-2W
    logic [7:0]        lb1_q [IMG_W];  // line n-W
    logic [7:0]        win_q [3][3];
    logic [7:0]        win_d [3][3];

    logic              space, run_step, fl_step, step, produce, border;
    logic [23:0]       pix_in;
    logic [9:0]        gsum;
    logic [7:0]        gray;
    logic signed [11:0] gx, gy;
    logic [11:0]       ax, ay, msum;
    logic [7:0]        mag, res;

    function automatic logic signed [11:0] sx(input logic [7:0] v);
        return $signed({4'b0000, v});
    endfunction

    assign space     = !out_valid_q || out_ready;
    assign in_ready  = (state_q == S_RUN) && space;
    assign run_step  = (state_q == S_RUN) && in_valid && space;
    // Flush steps run until the counter passes the last dummy-pixel step.
    assign fl_step   = (state_q == S_FLUSH) && (cnt_q != CW'(NPIX + IMG_W + 1)) && space;
    assign step      = run_step || fl_step;
    assign produce   = step && (cnt_q >= CW'(IMG_W + 1));

    assign pix_in    = run_step ? rgb : 24'h0;
    assign gsum      = {2'b00, pix_in[23:16]} + {1'b0, pix_in[15:8], 1'b0} + {2'b00, pix_in[7:0]};
    assign gray      = gsum[9:2];

    // Window after this step: shift left, new column = {two lines up, one line up, new pixel}.
    always_comb begin
        for (int r = 0; r < 3; r++) begin
            win_d[r][0] = win_q[r][1];
            win_d[r][1] = win_q[r][2];
        end
        win_d[0][2] = lb0_q[col_q];
        win_d[1][2] = lb1_q[col_q];
        win_d[2][2] = gray;
    end

    always_comb begin
        gx   = (sx(win_d[0][2]) + (sx(win_d[1][2]) <<< 1) + sx(win_d[2][2]))
             - (sx(win_d[0][0]) + (sx(win_d[1][0]) <<< 1) + sx(win_d[2][0]));
        gy   = (sx(win_d[2][0]) + (sx(win_d[2][1]) <<< 1) + sx(win_d[2][2]))
             - (sx(win_d[0][0]) + (sx(win_d[0][1]) <<< 1) + sx(win_d[0][2]));
        ax   = gx[11] ? 12'(-gx) : 12'(gx);
        ay   = gy[11] ? 12'(-gy) : 12'(gy);
        msum = ax + ay;
        mag  = (msum > 12'd255) ? 8'hFF : msum[7:0];
    end

    // Border centres would need wrapped neighbours, so they are forced to zero.
    assign border = (crow_q == '0) || (crow_q == YW'(IMG_H - 1)) ||
                    (ccol_q == '0) || (ccol_q == XW'(IMG_W - 1));

    always_comb begin
        res = 8'h00;
        case (mode_q)
            2'd2:    res = win_d[1][1];
            2'd1:    res = (!border && (mag >= thr_q)) ? 8'hFF : 8'h00;
            default: res = border ? 8'h00 : mag;
        endcase
    end

    // Line buffers hold no reset: every entry is rewritten before it reaches an interior output.
    always_ff @(posedge clk) begin
        if (step) begin
            lb0_q[col_q] <= lb1_q[col_q];
            lb1_q[col_q] <= gray;
        end
    end

    always_ff @(posedge clk) begin
        if (!n_rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            col_q       <= '0;
            ccol_q      <= '0;
            crow_q      <= '0;
            mode_q      <= 2'd0;
            thr_q       <= 8'h00;
            out_valid_q <= 1'b0;
            out_pix_q   <= 8'h00;
            out_addr_q  <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            ferr_q      <= 1'b0;
            for (int r = 0; r < 3; r++)
                for (int c = 0; c < 3; c++)
                    win_q[r][c] <= 8'h00;
        end else begin
            done_q <= 1'b0;
            if (state_q != S_IDLE && start)
                ferr_q <= 1'b1;

            if (state_q == S_RUN || state_q == S_FLUSH) begin
                if (step) begin
                    cnt_q <= cnt_q + 1'b1;
                    col_q <= (col_q == XW'(IMG_W - 1)) ? '0 : col_q + 1'b1;
                    win_q <= win_d;
                end
                if (produce) begin
                    out_valid_q <= 1'b1;
                    out_pix_q   <= res;
                    out_addr_q  <= ADDR_W'(cnt_q - CW'(IMG_W + 1));
                    if (ccol_q == XW'(IMG_W - 1)) begin
                        ccol_q <= '0;
                        crow_q <= crow_q + 1'b1;
                    end else begin
                        ccol_q <= ccol_q + 1'b1;
                    end
                end else if (out_ready) begin
                    out_valid_q <= 1'b0;
                end
            end

            case (state_q)
                S_IDLE: begin
                    if (start) begin
                        state_q     <= S_RUN;
                        cnt_q       <= '0;
                        col_q       <= '0;
                        ccol_q      <= '0;
                        crow_q      <= '0;
                        mode_q      <= mode;
                        thr_q       <= threshold;
                        out_valid_q <= 1'b0;
                        out_pix_q   <= 8'h00;
                        out_addr_q  <= '0;
                        busy_q      <= 1'b1;
                        ferr_q      <= 1'b0;
                        for (int r = 0; r < 3; r++)
                            for (int c = 0; c < 3; c++)
                                win_q[r][c] <= 8'h00;
                    end
                end
                S_RUN: begin
                    if (run_step && cnt_q == CW'(NPIX - 1))
                        state_q <= S_FLUSH;
                end
                S_FLUSH: begin
                    // All flush steps issued: finish once the last result is taken.
                    if (cnt_q == CW'(NPIX + IMG_W + 1) && out_valid_q && out_ready) begin
                        state_q <= S_DONE;
                        done_q  <= 1'b1;
                    end
                end
                default: begin
                    state_q <= S_IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign out_valid = out_valid_q;
    assign out_pix   = out_pix_q;
    assign out_addr  = out_addr_q;
    assign busy      = busy_q;
    assign done      = done_q;
    assign frame_err = ferr_q;
endmodule

// File: tb/tb_edge_stream_pipe.sv
// tb/tb_edge_stream_pipe.sv - self-checking bench for edge_stream_pipe
module tb_edge_stream_pipe;
    localparam int W = 4, H = 3, AW = 4, N = W * H;

    logic          clk = 1'b0;
    logic          n_rst, start, in_valid, out_ready;
    logic [1:0]    mode;
    logic [7:0]    threshold;
    logic [23:0]   rgb;
    logic          in_ready, out_valid, busy, done, frame_err;
    logic [7:0]    out_pix;
    logic [AW-1:0] out_addr;

    always #5 clk = ~clk;

    edge_stream_pipe #(.IMG_W(W), .IMG_H(H), .ADDR_W(AW)) dut (
        .clk(clk), .n_rst(n_rst), .start(start), .mode(mode), .threshold(threshold),
        .in_valid(in_valid), .in_ready(in_ready), .rgb(rgb),
        .out_valid(out_valid), .out_ready(out_ready), .out_pix(out_pix), .out_addr(out_addr),
        .busy(busy), .done(done), .frame_err(frame_err)
    );

    int total = 0, bad = 0;
    logic [23:0] img [N];
    logic [7:0]  got_pix [$];
    int          got_addr [$];
    int          exp_q [$];
    int          done_cycles, first_lat, stall_viol, ov_at_done;
    logic        ferr_at_start, busy_after, ready_after;
    bit          timed_out;

    function automatic int gr(int r, int c);
        logic [23:0] p;
        p = img[r * W + c];
        return (int'(p[23:16]) + 2 * int'(p[15:8]) + int'(p[7:0])) / 4;
    endfunction

    // Reference result straight from the neighbourhood definitions on the 2-D image.
    function automatic int model(int a, logic [1:0] m, logic [7:0] th);
        int r, c, gx, gy, mg;
        r = a / W;
        c = a % W;
        if (m == 2'd2) return gr(r, c);
        if (r == 0 || r == H - 1 || c == 0 || c == W - 1) return 0;
        gx = gr(r-1, c+1) + 2*gr(r, c+1) + gr(r+1, c+1) - gr(r-1, c-1) - 2*gr(r, c-1) - gr(r+1, c-1);
        gy = gr(r+1, c-1) + 2*gr(r+1, c) + gr(r+1, c+1) - gr(r-1, c-1) - 2*gr(r-1, c) - gr(r-1, c+1);
        mg = (gx < 0 ? -gx : gx) + (gy < 0 ? -gy : gy);
        if (mg > 255) mg = 255;
        if (m == 2'd1) return (mg >= int'(th)) ? 255 : 0;
        return mg;
    endfunction

    task automatic run_frame(input logic [1:0] m, input logic [7:0] th, input bit stall, input bit mid_start);
        int pi;
        bit hold;
        logic [7:0] hp;
        logic [AW-1:0] ha;
        got_pix.delete(); got_addr.delete(); exp_q.delete();
        for (int a = 0; a < N; a++) exp_q.push_back(model(a, m, th));
        done_cycles = 0; first_lat = -1; stall_viol = 0; ov_at_done = 0; timed_out = 1;
        pi = 0; hold = 0; hp = 0; ha = 0;
        @(negedge clk);
        start = 1; mode = m; threshold = th; in_valid = 0; out_ready = 1;
        @(negedge clk);
        start = 0; mode = 2'($urandom); threshold = 8'($urandom);
        #1 ferr_at_start = frame_err;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            out_ready = stall ? 1'($urandom_range(1, 0)) : 1'b1;
            in_valid  = (pi < N) && (!stall || $urandom_range(3, 0) != 0);
            rgb       = in_valid ? img[pi] : 24'($urandom);
            start     = mid_start && (pi == 5);
            #1;
            if (hold && !(out_valid && out_pix == hp && out_addr == ha)) stall_viol++;
            hold = out_valid && !out_ready; hp = out_pix; ha = out_addr;
            if (out_valid && first_lat < 0) first_lat = pi;
            if (out_valid && out_ready) begin
                got_pix.push_back(out_pix);
                got_addr.push_back(int'(out_addr));
            end
            if (in_valid && in_ready) pi++;
            if (done) begin
                done_cycles++;
                if (out_valid) ov_at_done = 1;
            end else if (done_cycles > 0) begin
                timed_out = 0;
                break;
            end
            @(negedge clk);
        end
        start = 0; in_valid = 0;
        busy_after = busy; ready_after = in_ready;
    endtask

    task automatic test_reset();
        n_rst = 0; start = 0; in_valid = 0; out_ready = 1; mode = 0; threshold = 0; rgb = 0;
        repeat (3) @(negedge clk);
        #1;
        total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL reset_in_ready got=%b exp=0", in_ready); end
        total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
        total++; if (out_pix !== 8'h00) begin bad++; $display("FAIL reset_out_pix got=%h exp=00", out_pix); end
        total++; if (out_addr !== '0) begin bad++; $display("FAIL reset_out_addr got=%h exp=0", out_addr); end
        total++; if (busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%b exp=0", busy); end
        total++; if (done !== 1'b0) begin bad++; $display("FAIL reset_done got=%b exp=0", done); end
        total++; if (frame_err !== 1'b0) begin bad++; $display("FAIL reset_frame_err got=%b exp=0", frame_err); end
        n_rst = 1;
    endtask

    task automatic test_flat();
        for (int i = 0; i < N; i++) img[i] = 24'h808080;
        run_frame(2'd0, 8'h00, 0, 0);
        total++; if (timed_out) begin bad++; $display("FAIL flat_timeout got=1 exp=0"); end
        total++; if (got_pix.size() != N) begin bad++; $display("FAIL flat_count got=%0d exp=%0d", got_pix.size(), N); end
        for (int i = 0; i < got_pix.size() && i < N; i++) begin
            total++;
            if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                begin bad++; $display("FAIL flat_out[%0d] got=%h@%0d exp=%h@%0d", i, got_pix[i], got_addr[i], exp_q[i], i); end
        end
        total++; if (done_cycles != 1) begin bad++; $display("FAIL flat_done_pulse got=%0d exp=1", done_cycles); end
        total++; if (busy_after !== 1'b0 || ready_after !== 1'b0) begin bad++; $display("FAIL flat_idle_after got=%b%b exp=00", busy_after, ready_after); end
        total++; if (ov_at_done != 0) begin bad++; $display("FAIL flat_valid_at_done got=%0d exp=0", ov_at_done); end
    endtask

    task automatic test_edge();
        for (int i = 0; i < N; i++) img[i] = (i % W < 2) ? 24'h000000 : 24'hFFFFFF;
        for (int pass = 0; pass < 2; pass++) begin
            run_frame(pass == 0 ? 2'd0 : 2'd3, 8'h00, 0, 0);
            total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL edge_count got=%0d exp=%0d", got_pix.size(), N); end
            for (int i = 0; i < got_pix.size() && i < N; i++) begin
                total++;
                if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                    begin bad++; $display("FAIL edge_out[%0d] got=%h@%0d exp=%h@%0d", i, got_pix[i], got_addr[i], exp_q[i], i); end
            end
            if (got_pix.size() == N) begin
                total++; if (got_pix[5] !== 8'hFF || got_pix[6] !== 8'hFF || got_pix[4] !== 8'h00)
                    begin bad++; $display("FAIL edge_known got=%h,%h,%h exp=00,ff,ff", got_pix[4], got_pix[5], got_pix[6]); end
            end
            total++; if (first_lat != W + 2) begin bad++; $display("FAIL edge_latency got=%0d exp=%0d", first_lat, W + 2); end
        end
    endtask

    task automatic test_threshold();
        logic [7:0] ths [3];
        ths[0] = 8'hFF; ths[1] = 8'h00; ths[2] = 8'($urandom_range(200, 20));
        for (int t = 0; t < 3; t++) begin
            if (t == 2) for (int i = 0; i < N; i++) img[i] = 24'($urandom);
            else for (int i = 0; i < N; i++) img[i] = (i % W < 2) ? 24'h000000 : 24'hFFFFFF;
            if (t == 1) img[5] = 24'h000000;
            run_frame(2'd1, ths[t], 0, 0);
            total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL thr_count got=%0d exp=%0d", got_pix.size(), N); end
            for (int i = 0; i < got_pix.size() && i < N; i++) begin
                total++;
                if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                    begin bad++; $display("FAIL thr%0d_out[%0d] got=%h exp=%h", t, i, got_pix[i], exp_q[i]); end
            end
        end
    endtask

    task automatic test_gray();
        for (int i = 0; i < N; i++) img[i] = 24'h102030;
        run_frame(2'd2, 8'h00, 0, 0);
        total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL gray_count got=%0d exp=%0d", got_pix.size(), N); end
        for (int i = 0; i < got_pix.size() && i < N; i++) begin
            total++;
            if (got_pix[i] !== 8'h20 || got_addr[i] != i)
                begin bad++; $display("FAIL gray_out[%0d] got=%h@%0d exp=20@%0d", i, got_pix[i], got_addr[i], i); end
        end
    endtask

    task automatic test_stall();
        for (int f = 0; f < 4; f++) begin
            logic [1:0] m;
            m = 2'($urandom);
            for (int i = 0; i < N; i++)
                case ($urandom_range(2, 0))
                    0: img[i] = 24'h000000;
                    1: img[i] = 24'hFFFFFF;
                    default: img[i] = 24'($urandom);
                endcase
            run_frame(m, 8'($urandom), 1, 0);
            total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL stall_count got=%0d exp=%0d", got_pix.size(), N); end
            for (int i = 0; i < got_pix.size() && i < N; i++) begin
                total++;
                if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                    begin bad++; $display("FAIL stall%0d_out[%0d] got=%h@%0d exp=%h@%0d", f, i, got_pix[i], got_addr[i], exp_q[i], i); end
            end
            total++; if (stall_viol != 0) begin bad++; $display("FAIL stall_hold got=%0d exp=0", stall_viol); end
            total++; if (done_cycles != 1) begin bad++; $display("FAIL stall_done got=%0d exp=1", done_cycles); end
        end
    endtask

    task automatic test_frame_err();
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        run_frame(2'd0, 8'h00, 0, 1);
        total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL ferr_count got=%0d exp=%0d", got_pix.size(), N); end
        for (int i = 0; i < got_pix.size() && i < N; i++) begin
            total++;
            if (got_pix[i] !== 8'(exp_q[i])) begin bad++; $display("FAIL ferr_out[%0d] got=%h exp=%h", i, got_pix[i], exp_q[i]); end
        end
        total++; if (frame_err !== 1'b1) begin bad++; $display("FAIL ferr_set got=%b exp=1", frame_err); end
        run_frame(2'd2, 8'h00, 0, 0);
        total++; if (ferr_at_start !== 1'b0) begin bad++; $display("FAIL ferr_clear got=%b exp=0", ferr_at_start); end
    endtask

    task automatic test_reset_mid();
        int pi;
        for (int i = 0; i < N; i++) img[i] = 24'($urandom);
        @(negedge clk);
        start = 1; mode = 2'd0; threshold = 8'h00; out_ready = 1;
        @(negedge clk);
        start = 0; pi = 0;
        for (int cyc = 0; cyc < 100 && pi < 7; cyc++) begin
            in_valid = 1; rgb = img[pi];
            #1 if (in_ready) pi++;
            @(negedge clk);
        end
        total++; if (pi != 7) begin bad++; $display("FAIL rmid_accept got=%0d exp=7", pi); end
        n_rst = 0; in_valid = 0;
        @(negedge clk);
        #1;
        total++; if ({in_ready, out_valid, busy, done, frame_err} !== 5'b0 || out_pix !== 8'h00 || out_addr !== '0)
            begin bad++; $display("FAIL rmid_cleared got=%b%b%b%b%b/%h/%h exp=00000/00/0", in_ready, out_valid, busy, done, frame_err, out_pix, out_addr); end
        n_rst = 1;
        run_frame(2'd0, 8'h00, 0, 0);
        total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL rmid_count got=%0d exp=%0d", got_pix.size(), N); end
        for (int i = 0; i < got_pix.size() && i < N; i++) begin
            total++;
            if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                begin bad++; $display("FAIL rmid_out[%0d] got=%h@%0d exp=%h@%0d", i, got_pix[i], got_addr[i], exp_q[i], i); end
        end
    endtask

    task automatic test_back_to_back();
        for (int f = 0; f < 3; f++) begin
            logic [1:0] m;
            logic [7:0] th;
            m = 2'($urandom); th = 8'($urandom);
            for (int i = 0; i < N; i++) img[i] = 24'($urandom);
            run_frame(m, th, 0, 0);
            total++; if (timed_out || got_pix.size() != N) begin bad++; $display("FAIL b2b_count got=%0d exp=%0d", got_pix.size(), N); end
            for (int i = 0; i < got_pix.size() && i < N; i++) begin
                total++;
                if (got_pix[i] !== 8'(exp_q[i]) || got_addr[i] != i)
                    begin bad++; $display("FAIL b2b%0d_out[%0d] got=%h exp=%h mode=%0d", f, i, got_pix[i], exp_q[i], m); end
            end
        end
    endtask

    initial begin
        test_reset();
        test_flat();
        test_edge();
        test_threshold();
        test_gray();
        test_stall();
        test_frame_err();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
